wide_add_seq: RTL and testbench



---
 rtl/wide_add_pkg.sv | 24 ++
 rtl/full_adder_16.sv | 28 ++
 rtl/wide_add_seq.sv | 133 +++++++++++++
 tb/tb_wide_add_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-beat wide adder sequencer.
// The word-select helper slices one N-bit word out of a zero-extended
// operand so the top can index words with a plain integer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADD_N         = 16;
    localparam int ADD_WORDS     = 4;
    localparam int ADD_MAX_WORDS = 16;

    // Return word idx (least-significant word is 0) of a maximally wide operand.
    function automatic logic [ADD_N-1:0] word_sel(
        input logic [ADD_N*ADD_MAX_WORDS-1:0] v,
        input int unsigned                    idx
    );
        return v[idx*ADD_N +: ADD_N];
    endfunction

endpackage

// File: rtl/full_adder_16.sv
// N-bit ripple-carry adder slice (16 bits by default). Purely combinational;
// the sequencer registers its carry-out between words.
module full_adder_16 #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    // Bit-serial ripple through the slice.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[N];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-beat wide-operand adder sequencer. Operands of WORDS x N bits are
// fed through one N-bit slice, least-significant word first, with the
// word carry registered between cycles.
// Handshakes: a beat transfers on an edge where valid && ready are both high;
// in_ready and out_valid are decoded straight from the state register.
// Optional macro WIDE_ADD_SUB_EN adds in_sub for A-B (out_cout=1: no borrow).
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int N     = ADD_N,
    parameter int WORDS = ADD_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    input  logic               in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_cout
);

    localparam int W  = N * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_t        state;
    logic [KW-1:0] k;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          cin_q;
    logic          carry_q;
    logic          cout_q;
    logic          sub_q;

    logic [ADD_N*ADD_MAX_WORDS-1:0] a_ext;
    logic [ADD_N*ADD_MAX_WORDS-1:0] b_ext;
    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_s;
    logic          slice_cin;
    logic          slice_cout;

    // Select the current word pair and the carry feeding the slice.
    always_comb begin
        a_ext          = '0;
        b_ext          = '0;
        a_ext[W-1:0]   = a_q;
        b_ext[W-1:0]   = b_q;
        slice_a        = word_sel(a_ext, 32'(k));
        slice_b        = word_sel(b_ext, 32'(k));
        slice_cin      = (k == '0) ? cin_q : carry_q;
        // Subtraction is A + ~B + 1: invert every B word, force word-0 carry.
        if (sub_q) begin
            slice_b = ~slice_b;
            if (k == '0) begin
                slice_cin = 1'b1;
            end
        end
    end

    full_adder_16 #(
        .N (N)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Control FSM plus operand, sum and carry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        cin_q <= in_cin;
`ifdef WIDE_ADD_SUB_EN
                        sub_q <= in_sub;
`else
                        sub_q <= 1'b0;
`endif
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[32'(k)*N +: N] <= slice_s;
                    carry_q              <= slice_cout;
                    if (k == K_LAST) begin
                        cout_q <= slice_cout;
                        k      <= '0;
                        state  <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq at the default size (4 x 16 bits).
module tb_wide_add_seq;

    localparam int N     = 16;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;

    int checks   = 0;
    int failures = 0;

    // Expected {cout, sum}, pushed at drive time, popped when a result shows.
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    wide_add_seq #(
        .N     (N),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef WIDE_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operand, check latency and result, hold out_ready low for
    // 'hold' cycles, then complete the result handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] esum, input logic ecout,
                          input int hold);
        logic [W:0] exp;
        int lat;
        int waitn;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        waitn    = 0;
        while (!in_ready && waitn < 20) begin
            @(negedge clk);
            waitn++;
        end
        check_val("in_ready_idle", (W+1)'(in_ready), (W+1)'(1));
        exp_q.push_back({ecout, esum});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", (W+1)'(lat), (W+1)'(WORDS + 1));
        exp = exp_q.pop_front();
        if (out_valid) begin
            check_val("sum", (W+1)'(out_sum), (W+1)'(exp[W-1:0]));
            check_val("cout", (W+1)'(out_cout), (W+1)'(exp[W]));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check_val("hold_valid", (W+1)'(out_valid), (W+1)'(1));
                check_val("hold_in_ready", (W+1)'(in_ready), (W+1)'(0));
                check_val("hold_sum", (W+1)'(out_sum), (W+1)'(exp[W-1:0]));
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_val("post_hs_valid", (W+1)'(out_valid), (W+1)'(0));
            check_val("post_hs_in_ready", (W+1)'(in_ready), (W+1)'(1));
            check_val("post_hs_sum", (W+1)'(out_sum), (W+1)'(exp[W-1:0]));
        end
    endtask

    initial begin
        logic [W:0]   model;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           seen_valid;

        // Reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
        check_val("rst_out_valid", (W+1)'(out_valid), (W+1)'(0));
        check_val("rst_sum", (W+1)'(out_sum), '0);
        check_val("rst_cout", (W+1)'(out_cout), '0);
        rst = 1'b0;

        // Directed vectors with hand-computed results
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 0});
        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 0});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
                         64'h2345_6789_ABCD_F002, 1'b0, 3});
        vecs.push_back('{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                         64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 0});
        vecs.push_back('{64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0,
                         64'h0001_0000_0000_0000, 1'b0, 0});
`ifdef WIDE_ADD_SUB_EN
        vecs.push_back('{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0});
        vecs.push_back('{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 0});
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].hold);
        end

        // Random operands against a 65-bit reference sum
        for (int i = 0; i < 8; i++) begin
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            rc    = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            run_op(ra, rb, rc, 1'b0, model[W-1:0], model[W], $urandom_range(0, 2));
        end

        // Reset two cycles into RUN discards the operation
        @(negedge clk);
        in_a     = 64'hDEAD_BEEF_0123_4567;
        in_b     = 64'h0F0F_F0F0_1234_8765;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("midrun_in_ready", (W+1)'(in_ready), (W+1)'(1));
        check_val("midrun_out_valid", (W+1)'(out_valid), (W+1)'(0));
        check_val("midrun_sum", (W+1)'(out_sum), '0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check_val("no_stale_valid", (W+1)'(seen_valid), '0);
        run_op(64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 0);

        check_val("queue_empty", (W+1)'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
